delay_line_param: RTL and testbench

Parametrised, stallable delay line with per-stage valid tagging, runtime-selectable latency, and synchronous flush. It is the general replacement for the fixed two-stage action/state/RAM-data delay blocks in the learning datapath: one instance covers any data width and any latency up to DEPTH. It sits between the action/state producers and the Q-table update logic, keeping operands aligned with RAM read latency.

---
 rtl/delay_line_param.sv | 98 +++++++++
 tb/tb_delay_line_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_param.sv
// Stallable, flushable delay line with per-stage valid tags and a runtime tap select.
// Define DELAY_OCC_EN to add the registered occupancy port and its counter.
module delay_line_param #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] tap_sel,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout
`ifdef DELAY_OCC_EN
  ,
  output logic [SEL_W-1:0] occupancy
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [SEL_W-1:0]            tap_idx;

  // Flush clears only the tags; data bits keep their old contents.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (en) begin
      data_d[0]  = din;
      valid_d[0] = din_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Out-of-range selects clamp to 1..DEPTH.
  always_comb begin
    tap_idx = SEL_W'(DEPTH - 1);
    if (tap_sel == '0) begin
      tap_idx = '0;
    end else if (tap_sel <= SEL_W'(DEPTH)) begin
      tap_idx = tap_sel - SEL_W'(1);
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_idx == SEL_W'(i)) begin
        dout       = data_q[i];
        dout_valid = valid_q[i];
      end
    end
  end

`ifdef DELAY_OCC_EN
  logic [SEL_W-1:0] occ_q, occ_d;

  // Incremental update tracks popcount of valid_q, so it stays within 0..DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + SEL_W'(din_valid) - SEL_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_delay_line_param.sv
// Scoreboard bench for delay_line_param: DEPTH=4/WIDTH=16 main instance plus a DEPTH=2/WIDTH=4 legacy instance.
module tb_delay_line_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, flush, din_valid;
  logic [15:0] din;
  logic [2:0]  tap_sel;
  logic        dout_valid;
  logic [15:0] dout;

  logic        l_en, l_flush, l_valid;
  logic [3:0]  l_din;
  logic [1:0]  l_tap;
  logic        l_dout_valid;
  logic [3:0]  l_dout;

`ifdef DELAY_OCC_EN
  logic [2:0]  occupancy;
  logic [1:0]  l_occ;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] d;
    logic        v;
    int          due;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  delay_line_param #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din_valid(din_valid),
    .din(din), .tap_sel(tap_sel), .dout_valid(dout_valid), .dout(dout)
`ifdef DELAY_OCC_EN
    , .occupancy(occupancy)
`endif
  );

  delay_line_param #(.WIDTH(4), .DEPTH(2)) legacy (
    .clk(clk), .rst(rst), .en(l_en), .flush(l_flush), .din_valid(l_valid),
    .din(l_din), .tap_sel(l_tap), .dout_valid(l_dout_valid), .dout(l_dout)
`ifdef DELAY_OCC_EN
    , .occupancy(l_occ)
`endif
  );

  task automatic tick(input logic e, input logic f, input logic v, input logic [15:0] d);
    en = e; flush = f; din_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (dout !== 16'h0 || dout_valid !== 1'b0) begin
      bad++; $display("FAIL reset_init: dout=%h valid=%b, want 0000/0", dout, dout_valid);
    end
`ifdef DELAY_OCC_EN
    total++;
    if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_init_occ: got %0d want 0", occupancy); end
`endif
    @(negedge clk);
    rst = 1'b0;
    tap_sel = 3'd4;
    for (int e = 1; e <= 4; e++) tick(1'b1, 1'b0, 1'b1, 16'h0F00 + 16'(e));
    total++;
    if (dout_valid !== 1'b1 || dout !== 16'h0F01) begin
      bad++; $display("FAIL reset_prefill: dout=%h valid=%b, want 0f01/1", dout, dout_valid);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (dout !== 16'h0 || dout_valid !== 1'b0) begin
      bad++; $display("FAIL reset_async: dout=%h valid=%b, want 0000/0", dout, dout_valid);
    end
`ifdef DELAY_OCC_EN
    total++;
    if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_async_occ: got %0d want 0", occupancy); end
`endif
    #2 rst = 1'b0;
    tap_sel = 3'd1;
    tick(1'b1, 1'b0, 1'b1, 16'h7777);
    total++;
    if (dout !== 16'h7777 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL reset_release_edge: dout=%h valid=%b, want 7777/1", dout, dout_valid);
    end
  endtask

  task automatic test_latency();
    logic [2:0] taps [6];
    taps = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    foreach (taps[k]) begin
      int n;
      n = (taps[k] == 3'd0) ? 1 : ((taps[k] > 3'd4) ? 4 : int'(taps[k]));
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      sbq.delete();
      tap_sel = taps[k];
      for (int e = 1; e <= 12; e++) begin
        logic v;
        logic exp_v;
        v = (e <= 6);
        if (v) sbq.push_back('{d: 16'(e), v: 1'b1, due: e + n - 1});
        tick(1'b1, 1'b0, v, 16'(e));
        exp_v = (sbq.size() > 0) && (sbq[0].due == e);
        total++;
        if (dout_valid !== exp_v) begin
          bad++; $display("FAIL latency_valid tap=%0d edge=%0d: got %b want %b", taps[k], e, dout_valid, exp_v);
        end else if (exp_v) begin
          total++;
          if (dout !== sbq[0].d) begin
            bad++; $display("FAIL latency_data tap=%0d edge=%0d: got %h want %h", taps[k], e, dout, sbq[0].d);
          end
          void'(sbq.pop_front());
        end
      end
      total++;
      if (sbq.size() != 0) begin
        bad++; $display("FAIL latency_drain tap=%0d: %0d words never emerged, want 0", taps[k], sbq.size());
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] prev;
    int ecount;
    tick(1'b0, 1'b1, 1'b0, 16'h0);
    sbq.delete();
    tap_sel = 3'd3;
    ecount = 0;
    prev = dout;
    for (int edge_n = 1; edge_n <= 8; edge_n++) begin
      logic e;
      logic exp_v;
      e = (edge_n == 1) || (edge_n >= 7);
      if (edge_n == 1) sbq.push_back('{d: 16'hA5A5, v: 1'b1, due: 3});
      tick(e, 1'b0, edge_n == 1, (edge_n == 1) ? 16'hA5A5 : 16'h0);
      if (e) ecount++;
      exp_v = (sbq.size() > 0) && (sbq[0].due == ecount);
      total++;
      if (dout_valid !== exp_v) begin
        bad++; $display("FAIL stall_valid edge=%0d: got %b want %b", edge_n, dout_valid, exp_v);
      end else if (exp_v) begin
        total++;
        if (dout !== sbq[0].d || edge_n != 8) begin
          bad++; $display("FAIL stall_emerge edge=%0d: got %h want a5a5 at edge 8", edge_n, dout);
        end
        void'(sbq.pop_front());
      end
      if (!e) begin
        total++;
        if (dout !== prev) begin
          bad++; $display("FAIL stall_frozen edge=%0d: got %h want %h", edge_n, dout, prev);
        end
      end
      prev = dout;
    end
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL stall_drain: %0d left want 0", sbq.size()); end
  endtask

  task automatic test_bubbles();
    logic pat [4];
    logic hist [$];
    int   maxocc;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    tick(1'b0, 1'b1, 1'b0, 16'h0);
    sbq.delete();
    tap_sel = 3'd4;
    maxocc = 0;
    for (int e = 1; e <= 8; e++) begin
      logic v;
      int   exp_occ;
      v = (e <= 4) ? pat[e-1] : 1'b0;
      sbq.push_back('{d: 16'h0100 + 16'(e), v: v, due: e + 3});
      hist.push_front(v);
      if (hist.size() > 4) void'(hist.pop_back());
      tick(1'b1, 1'b0, v, 16'h0100 + 16'(e));
      if (e >= 4) begin
        total++;
        if (dout_valid !== sbq[0].v) begin
          bad++; $display("FAIL bubble_valid edge=%0d: got %b want %b", e, dout_valid, sbq[0].v);
        end else if (sbq[0].v) begin
          total++;
          if (dout !== sbq[0].d) begin
            bad++; $display("FAIL bubble_data edge=%0d: got %h want %h", e, dout, sbq[0].d);
          end
        end
        void'(sbq.pop_front());
      end
      exp_occ = 0;
      foreach (hist[j]) if (hist[j]) exp_occ++;
`ifdef DELAY_OCC_EN
      total++;
      if (int'(occupancy) != exp_occ) begin
        bad++; $display("FAIL bubble_occ edge=%0d: got %0d want %0d", e, occupancy, exp_occ);
      end
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
`endif
    end
`ifdef DELAY_OCC_EN
    total++;
    if (maxocc != 3) begin bad++; $display("FAIL bubble_occ_peak: got %0d want 3", maxocc); end
`endif
  endtask

  task automatic test_flush();
    tick(1'b0, 1'b1, 1'b0, 16'h0);
    tap_sel = 3'd4;
    for (int e = 1; e <= 4; e++) tick(1'b1, 1'b0, 1'b1, 16'h0C00 + 16'(e));
`ifdef DELAY_OCC_EN
    total++;
    if (occupancy !== 3'd4) begin bad++; $display("FAIL flush_full_occ: got %0d want 4", occupancy); end
`endif
    tick(1'b1, 1'b1, 1'b1, 16'hDEAD);
    for (int t = 1; t <= 4; t++) begin
      tap_sel = 3'(t);
      #1;
      total++;
      if (dout_valid !== 1'b0) begin
        bad++; $display("FAIL flush_valid tap=%0d: got %b want 0", t, dout_valid);
      end
    end
    tap_sel = 3'd1;
    #1;
    total++;
    if (dout !== 16'h0C04) begin
      bad++; $display("FAIL flush_data_held: got %h want 0c04 (input dropped)", dout);
    end
`ifdef DELAY_OCC_EN
    total++;
    if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
`endif
    tap_sel = 3'd4;
    for (int e = 1; e <= 4; e++) begin
      tick(1'b1, 1'b0, 1'b0, 16'h0);
      total++;
      if (dout_valid !== 1'b0) begin
        bad++; $display("FAIL flush_no_ghost edge=%0d: got %b want 0", e, dout_valid);
      end
    end
  endtask

  task automatic test_legacy();
    logic [3:0] r1, r2;
    r1 = 4'h0;
    r2 = 4'h0;
    for (int c = 0; c < 24; c++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      l_din = d;
      @(posedge clk);
      r2 = r1;
      r1 = d;
      #1;
      total++;
      if (l_dout !== r2 || l_dout_valid !== 1'b1) begin
        bad++; $display("FAIL legacy cycle=%0d: dout=%h valid=%b, want %h/1", c, l_dout, l_dout_valid, r2);
      end
    end
  endtask

  initial begin
    en = 1'b0; flush = 1'b0; din_valid = 1'b0; din = 16'h0; tap_sel = 3'd1;
    l_en = 1'b1; l_flush = 1'b0; l_valid = 1'b1; l_din = 4'h0; l_tap = 2'd2;
    test_reset();
    test_latency();
    test_stall();
    test_bubbles();
    test_flush();
    test_legacy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
